// File: rtl/softmax_pkg.sv
// Shared constants for the softmax exponent-buffer sequencer and its FIFO instances.
// State encoding, default depth/counter widths and a length clamp helper.
package softmax_pkg;

  localparam int FIFO_SIZE_DEF = 7;
  localparam int CNT_WIDTH_DEF = 4;
  localparam int STATE_W       = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FILL  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic int clamp_len(input int req, input int max_len);
    return (req > max_len) ? max_len : req;
  endfunction

endpackage

// File: rtl/fifo_seq_cnt.sv
// Word counter with synchronous clear, saturating at len; term flags cnt==len.
// Registered count, combinational terminal flag; inc ignored once saturated.
module fifo_seq_cnt #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclr,
  input  logic                 inc,
  input  logic [CNT_WIDTH-1:0] len,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 term
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (sclr) begin
      cnt <= '0;
    end else if (inc && (cnt < len)) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  assign term = (cnt == len);

endmodule

// File: rtl/fifo_seq_ctrl.sv
// Exponent-buffer sequencer: pointer clear, FILL of len words, hold for sum, replay to divider.
// Zero-bubble fill/drain; out_valid trails rd_en by one cycle. Optional FIFO_CTRL_ERR_EN adds sticky err.
module fifo_seq_ctrl
  import softmax_pkg::*;
#(
  parameter int FIFO_SIZE = FIFO_SIZE_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk1,
  input  logic                 clr,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] vec_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sum_done,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic                 fifo_wr_en,
  output logic                 fifo_wr_inc,
  output logic                 fifo_rd_en,
  output logic                 fifo_rd_inc,
  output logic                 fifo_wr_clr,
  output logic                 fifo_rd_clr,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_t               state;
  logic [CNT_WIDTH-1:0] len;
  logic [CNT_WIDTH-1:0] len_req;
  logic [CNT_WIDTH-1:0] wr_cnt;
  logic [CNT_WIDTH-1:0] rd_cnt;
  logic                 wr_term;
  logic                 rd_term;
  logic                 sum_seen;
  logic                 ptr_clr;
  logic                 done_q;
  logic                 ov_q;
  logic                 fill_last;
  logic                 start_ok;

  assign len_req  = CNT_WIDTH'(clamp_len(int'(vec_len), FIFO_SIZE));
  assign start_ok = start && (state == ST_IDLE);

  assign in_ready    = (state == ST_FILL) && (wr_cnt < len);
  assign fifo_wr_en  = in_valid && in_ready;
  assign fifo_wr_inc = fifo_wr_en;
  assign fifo_rd_en  = (state == ST_DRAIN) && out_ready && (rd_cnt < len);
  assign fifo_rd_inc = fifo_rd_en;
  assign fifo_wr_clr = ptr_clr;
  assign fifo_rd_clr = ptr_clr;
  assign out_valid   = ov_q;
  assign busy        = (state != ST_IDLE);
  assign done        = done_q;

  // Leave FILL on the edge that accepts the last word so the drain has no bubble.
  assign fill_last = wr_term || (fifo_wr_en && (wr_cnt == (len - CNT_WIDTH'(1))));

  fifo_seq_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
    .clk  (clk1),
    .rst  (clr),
    .sclr (state == ST_CLR),
    .inc  (fifo_wr_inc),
    .len  (len),
    .cnt  (wr_cnt),
    .term (wr_term)
  );

  fifo_seq_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_rd_cnt (
    .clk  (clk1),
    .rst  (clr),
    .sclr (state == ST_CLR),
    .inc  (fifo_rd_inc),
    .len  (len),
    .cnt  (rd_cnt),
    .term (rd_term)
  );

  always_ff @(posedge clk1 or posedge clr) begin
    if (clr) begin
      state    <= ST_IDLE;
      len      <= '0;
      sum_seen <= 1'b0;
      ptr_clr  <= 1'b0;
      done_q   <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      ptr_clr <= 1'b0;
      done_q  <= 1'b0;
      ov_q    <= fifo_rd_en;
      if ((state != ST_IDLE) && sum_done) begin
        sum_seen <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          sum_seen <= 1'b0;
          if (start) begin
            len <= len_req;
            if (len_req == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state   <= ST_CLR;
              ptr_clr <= 1'b1;
            end
          end
        end
        ST_CLR: begin
          state <= ST_FILL;
        end
        ST_FILL: begin
          if (fill_last) begin
            state <= sum_seen ? ST_DRAIN : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sum_seen) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // out_valid for the final word coincides with rd_cnt reaching len.
          if (ov_q && rd_term) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic err_q;

  always_ff @(posedge clk1 or posedge clr) begin
    if (clr) begin
      err_q <= 1'b0;
    end else if (start_ok) begin
      err_q <= 1'b0;
    end else if ((in_valid && ((state == ST_WAIT) || (state == ST_DRAIN))) ||
                 (start && (state != ST_IDLE))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign err = 1'b0;
`endif

endmodule
